pc_stack: RTL

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_pkg.sv | 25 ++
 rtl/ret_stack.sv | 54 +++++
 rtl/pc_stack.sv | 106 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter block: branch condition codes
// and the helper that resolves a condition against the E/G flags.
package pc_pkg;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'd0,
        COND_IF_E   = 2'd1,
        COND_IF_G   = 2'd2,
        COND_IF_EG  = 2'd3
    } cond_e;

    // Resolve a branch condition code against the equal/greater flags.
    function automatic logic cond_eval(input cond_e sel, input logic e, input logic g);
        logic res;
        case (sel)
            COND_ALWAYS: res = 1'b1;
            COND_IF_E:   res = e;
            COND_IF_G:   res = g;
            COND_IF_EG:  res = e | g;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Entries are never cleared; only the fill count is,
// so contents after a clear are don't-care and unreachable until rewritten.
module ret_stack #(
    parameter int D     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [D-1:0]               push_data,
    output logic [D-1:0]               top,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [D-1:0]  mem_r [DEPTH];
    logic [CW-1:0] count_r;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] top_idx_s;

    // Derive write slot, top slot and fill status from the current count.
    always_comb begin
        wr_idx_s  = count_r[AW-1:0];
        top_idx_s = count_r[AW-1:0] - AW'(1'b1);
        full      = (count_r == CW'(DEPTH));
        empty     = (count_r == {CW{1'b0}});
        if (empty) begin
            top = {D{1'b0}};
        end else begin
            top = mem_r[top_idx_s];
        end
    end

    // Pop has precedence over push; the caller guarantees full/empty gating.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (pop && !empty) begin
            count_r <= count_r - CW'(1'b1);
        end else if (push && !full) begin
            mem_r[wr_idx_s] <= push_data;
            count_r         <= count_r + CW'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pc_stack.sv
// Program counter with conditional absolute/relative jumps, subroutine
// call/return through a return-address stack, and sticky overflow/underflow
// flags. Priority per cycle: reset|start > stall > ret > call > jump > +1.
module pc_stack
    import pc_pkg::*;
#(
    parameter int D     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stall,
    input  logic                       jump_en,
    input  logic                       jump_abs,
    input  logic [1:0]                 cond_sel,
    input  logic                       E,
    input  logic                       G,
    input  logic                       call,
    input  logic                       ret,
    input  logic [D-1:0]               target,
    output logic [D-1:0]               prog_ctr,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       overflow,
    output logic                       underflow
);
    logic [D-1:0] prog_ctr_r;
    logic         overflow_r;
    logic         underflow_r;

    logic [D-1:0] pc_inc_s;
    logic [D-1:0] jump_dest_s;
    logic [D-1:0] top_s;
    logic         cond_true_s;
    logic         clear_s;
    logic         push_s;
    logic         pop_s;
    logic         full_s;
    logic         empty_s;

    // Next-address candidates and stack handshakes; stack moves only when
    // the corresponding request actually wins this cycle.
    always_comb begin
        pc_inc_s    = prog_ctr_r + D'(1'b1);
        cond_true_s = cond_eval(cond_e'(cond_sel), E, G);
        if (jump_abs) begin
            jump_dest_s = target;
        end else begin
            jump_dest_s = prog_ctr_r + target;
        end
        clear_s = reset | start;
        pop_s   = ~clear_s & ~stall & ret & ~empty_s;
        push_s  = ~clear_s & ~stall & ~ret & call & ~full_s;
    end

    ret_stack #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .clear     (clear_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top       (top_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (sp)
    );

    // Program counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            prog_ctr_r  <= {D{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (stall) begin
            prog_ctr_r  <= prog_ctr_r;
            overflow_r  <= overflow_r;
            underflow_r <= underflow_r;
        end else if (ret) begin
            if (!empty_s) begin
                prog_ctr_r <= top_s;
            end else begin
                prog_ctr_r  <= pc_inc_s;
                underflow_r <= 1'b1;
            end
        end else if (call) begin
            if (!full_s) begin
                prog_ctr_r <= target;
            end else begin
                prog_ctr_r <= pc_inc_s;
                overflow_r <= 1'b1;
            end
        end else if (jump_en && cond_true_s) begin
            prog_ctr_r <= jump_dest_s;
        end else begin
            prog_ctr_r <= pc_inc_s;
        end
    end

    assign prog_ctr  = prog_ctr_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule
